// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, grant ids and default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_LDR = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } grant_id_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating watchdog counter for the arbiter's grant phase; expired is raised in the
// LIMIT-th consecutive enabled cycle after a clear.
module mem_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(LIMIT))) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Count is k-1 in the k-th enabled cycle, so compare against LIMIT-1.
    assign o_expired = (r_count >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a program loader.
// Define MEM_ARB_TIMEOUT_EN to enable the grant-phase watchdog (err pulse on abort).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    grant_id_e         r_last_grant;
    grant_id_e         w_grant_id;
    logic              w_grant_valid;
    logic              w_cpu_req;
    logic              w_ldr_req;
    logic              w_in_gnt;
    logic              w_timeout;
    logic [DATA_W-1:0] r_cap_rdata;

    // A requester still showing req in its own ack cycle is not a new request.
    assign w_cpu_req = cpu_req & ~cpu_ack;
    assign w_ldr_req = ldr_req & ~ldr_ack;
    assign w_in_gnt  = (r_state == GNT_CPU) || (r_state == GNT_LDR);
    assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_expired;
    logic r_err;

    mem_arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (~w_in_gnt),
        .i_enable  (w_in_gnt),
        .o_expired (w_expired)
    );

    // A real ack in the last allowed cycle wins over the watchdog.
    assign w_timeout = w_in_gnt & w_expired & ~mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_id    = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_cpu_req && w_ldr_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = (r_last_grant == CPU) ? LDR : CPU;
                end else if (w_cpu_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = CPU;
                end else if (w_ldr_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = LDR;
                end
                if (w_grant_valid) begin
                    w_state_next = (w_grant_id == CPU) ? GNT_CPU : GNT_LDR;
                end
            end
            GNT_CPU, GNT_LDR: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= LDR;
            r_cap_rdata  <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            ldr_ack      <= 1'b0;
            ldr_rdata    <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_last_grant <= w_grant_id;
                        mem_req      <= 1'b1;
                        if (w_grant_id == CPU) begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            mem_we    <= ldr_we;
                            mem_addr  <= ldr_addr;
                            mem_wdata <= ldr_wdata;
                        end
                    end
                end
                GNT_CPU, GNT_LDR: begin
                    if (mem_ack) begin
                        r_cap_rdata <= mem_rdata;
                    end
                    if (mem_ack || w_timeout) begin
                        mem_req <= 1'b0;
                    end
                end
                DONE: begin
                    // err is high only in DONE after an aborted access; keep old rdata then.
                    if (r_last_grant == CPU) begin
                        cpu_ack <= 1'b1;
                        if (!err) begin
                            cpu_rdata <= r_cap_rdata;
                        end
                    end else begin
                        ldr_ack <= 1'b1;
                        if (!err) begin
                            ldr_rdata <= r_cap_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (used only under REQ-026).
REQ-004 SHALL have ports: clk  in  1  single clock; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W; CPU datapath access request.
REQ-006 SHALL have ports: cpu_ack out 1, cpu_rdata out DATA_W, cpu_stall out 1; CPU completion, read data, and stall to control_unit.
REQ-007 SHALL have ports: ldr_req in 1, ldr_we in 1, ldr_addr in ADDR_W, ldr_wdata in DATA_W, ldr_ack out 1, ldr_rdata out DATA_W; program-loader port.
REQ-008 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ack in 1; single shared memory port.
REQ-009 SHALL have port err out 1; one-cycle pulse on aborted access (tied 0 when REQ-026 is off).

Function
REQ-010 SHALL implement FSM states IDLE, GNT_CPU, GNT_LDR, DONE.
REQ-011 In IDLE, if exactly one requester has req=1, SHALL grant it on the next clock edge.
REQ-012 In IDLE with both requesting, SHALL grant the requester not recorded in last_grant (round-robin), then update last_grant.
REQ-013 At grant, SHALL latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata and set mem_req=1, all registered.
REQ-014 In GNT_*, SHALL hold mem_req and the latched fields stable until mem_ack=1, regardless of requester input changes.
REQ-015 On mem_ack=1 in GNT_*, SHALL capture mem_rdata (also on writes), drop mem_req, and go to DONE.
REQ-016 In DONE, SHALL pulse the granted requester's ack for exactly one cycle with its rdata valid, then return to IDLE.
REQ-017 Requesters SHALL hold req and fields until ack and drop req in the ack cycle; the arbiter SHALL NOT re-grant from DONE.
REQ-018 Minimum latency, req high in IDLE to ack: 3 cycles with mem_ack in the first GNT cycle.
REQ-019 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-020 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the memory access.
REQ-021 xxx_rdata SHALL hold its last value until the next completion on that port.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, both acks=0, both rdata=0, err=0.
REQ-023 reset SHALL set last_grant=LDR, so the CPU wins the first tie.
REQ-024 Reset asserted mid-access SHALL drop mem_req immediately without an ack; a late mem_ack after reset release SHALL be ignored in IDLE.
REQ-025 Reset release SHALL be synchronised by the instantiating level; the block assumes a glitch-free release.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL run in GNT_*; after TIMEOUT cycles without mem_ack, the block SHALL drop mem_req, pulse err for one cycle, pulse the requester's ack with rdata unchanged, and go through DONE to IDLE.
REQ-027 Macro MEM_ARB_TIMEOUT_EN undefined: no counter; GNT_* SHALL wait on mem_ack indefinitely; err SHALL be constant 0.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, the grant-id enum (CPU, LDR), and default ADDR_W/DATA_W constants.
REQ-029 Sub-module mem_arb_timer (saturating counter, clear/enable/expired) SHALL implement the watchdog; it is instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-030 CPU read alone, cpu_addr=0x40, memory acks at cycle 1 with 0xDEADBEEF -> mem_addr=0x40, cpu_ack 3 cycles after req, cpu_rdata=0xDEADBEEF, cpu_stall high until ack.
REQ-031 Both req the first cycle after reset -> CPU granted first, LDR granted next; alternation on 4 back-to-back contended accesses: CPU,LDR,CPU,LDR.
REQ-032 LDR write addr=0x100 data=0x12345678, mem_ack delayed 5 cycles; cpu_addr toggles meanwhile -> mem_addr/mem_wdata stay 0x100/0x12345678; ldr_ack 1 cycle after DONE entry.
REQ-033 Reset pulled low in GNT_CPU -> mem_req=0 the same cycle, no cpu_ack; mem_ack=1 after release -> no ack, state IDLE.
REQ-034 MEM_ARB_TIMEOUT_EN, TIMEOUT=8, mem_ack never -> err and cpu_ack pulse after 8 GNT cycles; next LDR request served normally.
REQ-035 cpu_req pulsed 1 cycle while LDR in GNT_LDR -> CPU not granted after DONE; mem port returns to IDLE.
